// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the parity rule used by both link ends.
package uart_pkg;

    localparam int unsigned MAX_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Zero-extension of narrower words leaves the reduction unchanged.
    function automatic logic par(input logic [MAX_DATA_W-1:0] data, input logic odd_or_even);
        return odd_or_even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side result bus of the UART receiver.
interface uart_receiver_if #(
    parameter int unsigned data_width = 8
) ();

    logic [data_width-1:0] data_out;
    logic                  rx_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output data_out,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        input data_out,
        input rx_valid,
        input parity_err,
        input frame_err,
        input busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], d};
        end
    end

    assign q = sync_ff[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start-bit validation, mid-bit sampling on an oversample tick,
// optional parity, stop check, one-cycle result strobe to the host.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned oversample = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                rx_tick,
    input  logic                parity_en,
    input  logic                odd_or_even_parity,
    uart_receiver_if.master     host
);

    localparam int unsigned TICK_W   = $clog2(oversample);
    localparam int unsigned BIT_W    = $clog2(data_width);
    localparam int unsigned TICK_MID = oversample / 2 - 1;
    localparam int unsigned TICK_END = oversample - 1;
    localparam int unsigned BIT_END  = data_width - 1;

    logic                  rx_s;
    uart_state_t           state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic                  odd_q, odd_d;
    logic                  armed_q, armed_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  tick_mid, tick_last;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tick_mid  = (tick_q == TICK_W'(TICK_MID));
    assign tick_last = (tick_q == TICK_W'(TICK_END));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            odd_q     <= 1'b0;
            armed_q   <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            odd_q     <= odd_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Everything advances only on rx_tick; armed blocks re-triggering on a held-low (break) line.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        odd_d     = odd_q;
        armed_d   = armed_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        if (rx_tick) begin
            case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d  = START;
                        tick_d   = '0;
                        par_en_d = parity_en;
                        odd_d    = odd_or_even_parity;
                    end
                end
                START: begin
                    if (tick_mid) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        tick_d         = '0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == BIT_W'(BIT_END)) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                PARITY: begin
                    if (tick_last) begin
                        tick_d    = '0;
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        tick_d  = '0;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = ~rx_s;
                        perr_d  = par_en_q & (par_bit_q != par(MAX_DATA_W'(shift_q), odd_q));
                        armed_d = rx_s;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign host.data_out   = data_q;
    assign host.rx_valid   = valid_q;
    assign host.parity_err = perr_q;
    assign host.frame_err  = ferr_q;
    assign host.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a bit-level line driver plus hand-computed expectations.
module tb_uart_receiver;

    localparam int unsigned DW       = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLKS = OS * TICK_DIV;

    logic clk                = 1'b0;
    logic rst                = 1'b0;
    logic rx                 = 1'b1;
    logic rx_tick            = 1'b0;
    logic parity_en          = 1'b0;
    logic odd_or_even_parity = 1'b0;

    int unsigned tdiv      = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          valid_cnt = 0;
    int          n0;
    int          idx;
    logic [7:0]  cap_q[$];

    uart_receiver_if #(.data_width(DW)) host ();

    uart_receiver #(
        .data_width (DW),
        .oversample (OS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx                 (rx),
        .rx_tick            (rx_tick),
        .parity_en          (parity_en),
        .odd_or_even_parity (odd_or_even_parity),
        .host               (host)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tdiv == TICK_DIV - 1) begin
            tdiv    = 0;
            rx_tick = 1'b1;
        end else begin
            tdiv    = tdiv + 1;
            rx_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (host.rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            cap_q.push_back(host.data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic stop);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bits(1);
        end
        if (has_par) begin
            rx = pbit;
            wait_bits(1);
        end
        rx = stop;
        wait_bits(1);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_bits(n);
    endtask

    function automatic logic [31:0] cap_at(input int i);
        return (cap_q.size() > i) ? 32'(cap_q[i]) : 32'hdead;
    endfunction

    initial begin
        // reset state
        repeat (5) @(negedge clk);
        check("rst_data", 32'(host.data_out), 32'h00);
        check("rst_valid", 32'(host.rx_valid), 32'h0);
        check("rst_perr", 32'(host.parity_err), 32'h0);
        check("rst_ferr", 32'(host.frame_err), 32'h0);
        check("rst_busy", 32'(host.busy), 32'h0);
        rst = 1'b1;
        idle_bits(1);

        // plain 8N1 frame
        n0 = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        check("t1_count", 32'(valid_cnt - n0), 32'd1);
        check("t1_data", 32'(host.data_out), 32'hA5);
        check("t1_perr", 32'(host.parity_err), 32'h0);
        check("t1_ferr", 32'(host.frame_err), 32'h0);

        // even parity: ^8'h03 = 0, so parity bit 0 is correct and 1 is wrong
        parity_en          = 1'b1;
        odd_or_even_parity = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        check("t2a_data", 32'(host.data_out), 32'h03);
        check("t2a_perr", 32'(host.parity_err), 32'h0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        check("t2b_data", 32'(host.data_out), 32'h03);
        check("t2b_perr", 32'(host.parity_err), 32'h1);

        // short low glitch rejected, then a clean frame
        parity_en = 1'b0;
        n0 = valid_cnt;
        rx = 1'b0;
        repeat (5 * TICK_DIV) @(negedge clk);
        idle_bits(1);
        check("t3_busy", 32'(host.busy), 32'h0);
        check("t3_noval", 32'(valid_cnt - n0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        check("t3_count", 32'(valid_cnt - n0), 32'd1);
        check("t3_data", 32'(host.data_out), 32'h5A);
        check("t3_perr", 32'(host.parity_err), 32'h0);

        // reset in the middle of the data bits of 8'hC3
        n0 = valid_cnt;
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = (i < 2) ? 1'b1 : 1'b0;
            wait_bits(1);
        end
        check("t5_busy_mid", 32'(host.busy), 32'h1);
        rst = 1'b0;
        #1;
        check("t5_rst_data", 32'(host.data_out), 32'h00);
        check("t5_rst_busy", 32'(host.busy), 32'h0);
        check("t5_rst_valid", 32'(host.rx_valid), 32'h0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        idle_bits(2);
        check("t5_noval", 32'(valid_cnt - n0), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        check("t5_data", 32'(host.data_out), 32'h3C);
        check("t5_ferr", 32'(host.frame_err), 32'h0);
        check("t5_count", 32'(valid_cnt - n0), 32'd1);

        // stop bit low followed by a break: one frame only until the line rises
        n0 = valid_cnt;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        wait_bits(3);
        check("t4_count", 32'(valid_cnt - n0), 32'd1);
        check("t4_data", 32'(host.data_out), 32'hFF);
        check("t4_ferr", 32'(host.frame_err), 32'h1);
        idle_bits(2);
        check("t4_nosecond", 32'(valid_cnt - n0), 32'd1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        check("t4_count2", 32'(valid_cnt - n0), 32'd2);
        check("t4_data2", 32'(host.data_out), 32'h00);
        check("t4_ferr2", 32'(host.frame_err), 32'h0);

        // back-to-back frames without an idle gap
        n0  = valid_cnt;
        idx = cap_q.size();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        check("t6_count", 32'(valid_cnt - n0), 32'd2);
        check("t6_first", cap_at(idx), 32'h01);
        check("t6_second", cap_at(idx + 1), 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
